// File: rtl/router_port_pkg.sv
// Shared types for the router port: packet word, byte count and FSM state encodings.
package router_port_pkg;

    localparam int BYTES_PER_PKT = 4;

    typedef logic [8*BYTES_PER_PKT-1:0] pkt_t;

    typedef enum logic {RX_IDLE, RX_BYTES} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    function automatic logic [7:0] pkt_byte(input pkt_t pkt, input logic [1:0] idx);
        return pkt[8*idx +: 8];
    endfunction

endpackage

// File: rtl/router_port_pkt_fifo.sv
// Packet queue with combinational head read; accepts a push on a full queue only when a pop
// happens on the same edge.
module pkt_fifo
    import router_port_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         i_push,
    input  pkt_t                         i_data,
    input  logic                         i_pop,
    output pkt_t                         o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    pkt_t          r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_doPush;
    logic          w_doPop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= next_ptr(r_wrPtr);
            end
            if (w_doPop) begin
                r_rdPtr <= next_ptr(r_rdPtr);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/router_port.sv
// Node-facing router port: byte-serial link to the node, whole packets to the router core,
// one packet queue per direction.
module router_port
    import router_port_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       put_inbound,
    input  logic [7:0] payload_inbound,
    output logic       free_inbound,
    input  logic       free_outbound,
    output logic       put_outbound,
    output logic [7:0] payload_outbound,
    output pkt_t       in_pkt,
    output logic       in_valid,
    input  logic       in_ready,
    input  pkt_t       out_pkt,
    input  logic       out_valid,
    output logic       out_ready,
    output logic       proto_err
);

    localparam int CW = $clog2(DEPTH + 1);

    rx_state_t   r_rxState, w_rxStateNext;
    logic [1:0]  r_rxCount, w_rxCountNext;
    pkt_t        r_rxData, w_rxDataNext;
    logic        r_freeIn;
    logic        r_protoErr;
    logic        w_inPush, w_inPushOk, w_inPop, w_protoSet;
    logic        w_inFull, w_inEmpty;
    logic [CW-1:0] w_inCount;
    logic [CW:0]   w_inCountNext;

    tx_state_t   r_txState, w_txStateNext;
    logic [1:0]  r_txSel, w_txSelNext;
    pkt_t        r_txShreg, w_txShregNext;
    logic        r_putOut, w_putOutNext;
    logic [7:0]  r_payloadOut, w_payloadOutNext;
    logic        w_txPop, w_outPush;
    logic        w_outEmpty, w_unusedOutFull;
    logic [CW-1:0] w_outCount;
    pkt_t        w_outHead;

    pkt_fifo #(.DEPTH(DEPTH)) u_inFifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (w_inPush),
        .i_data  (w_rxDataNext),
        .i_pop   (w_inPop),
        .o_data  (in_pkt),
        .o_full  (w_inFull),
        .o_empty (w_inEmpty),
        .o_count (w_inCount)
    );

    pkt_fifo #(.DEPTH(DEPTH)) u_outFifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_push  (w_outPush),
        .i_data  (out_pkt),
        .i_pop   (w_txPop),
        .o_data  (w_outHead),
        .o_full  (w_unusedOutFull),
        .o_empty (w_outEmpty),
        .o_count (w_outCount)
    );

    assign in_valid         = !w_inEmpty;
    assign w_inPop          = in_valid && in_ready;
    assign w_inPushOk       = w_inPush && (!w_inFull || w_inPop);
    assign w_inCountNext    = {1'b0, w_inCount} + (CW+1)'(w_inPushOk) - (CW+1)'(w_inPop);
    assign out_ready        = (w_outCount < CW'(DEPTH));
    assign w_outPush        = out_valid && out_ready;
    assign free_inbound     = r_freeIn;
    assign proto_err        = r_protoErr;
    assign put_outbound     = r_putOut;
    assign payload_outbound = r_payloadOut;

    // Inbound bytes arrive MSB first; the fourth byte pushes the assembled word on the same edge.
    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxCountNext = r_rxCount;
        w_rxDataNext  = r_rxData;
        w_inPush      = 1'b0;
        w_protoSet    = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (put_inbound) begin
                    if (r_freeIn) begin
                        w_rxDataNext[31:24] = payload_inbound;
                        w_rxCountNext       = 2'd1;
                        w_rxStateNext       = RX_BYTES;
                    end else begin
                        w_protoSet = 1'b1;
                    end
                end
            end
            RX_BYTES: begin
                if (put_inbound) begin
                    w_rxDataNext[8*((BYTES_PER_PKT-1) - int'(r_rxCount)) +: 8] = payload_inbound;
                    w_rxCountNext = r_rxCount + 2'd1;
                    if (r_rxCount == 2'(BYTES_PER_PKT - 1)) begin
                        w_inPush      = 1'b1;
                        w_rxStateNext = RX_IDLE;
                    end
                end
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_rxState  <= RX_IDLE;
            r_rxCount  <= '0;
            r_rxData   <= '0;
            r_freeIn   <= 1'b0;
            r_protoErr <= 1'b0;
        end else begin
            r_rxState  <= w_rxStateNext;
            r_rxCount  <= w_rxCountNext;
            r_rxData   <= w_rxDataNext;
            r_freeIn   <= (w_rxStateNext == RX_IDLE) && (w_inCountNext < (CW+1)'(DEPTH));
            r_protoErr <= r_protoErr || w_protoSet;
        end
    end

    // Outbound bytes leave LSB first; free_outbound only matters when choosing to start a packet.
    always_comb begin
        w_txStateNext    = r_txState;
        w_txSelNext      = r_txSel;
        w_txShregNext    = r_txShreg;
        w_putOutNext     = 1'b0;
        w_payloadOutNext = 8'h00;
        w_txPop          = 1'b0;
        case (r_txState)
            TX_IDLE: begin
                if (!w_outEmpty && free_outbound) begin
                    w_txPop       = 1'b1;
                    w_txShregNext = w_outHead;
                    w_txSelNext   = 2'd0;
                    w_txStateNext = TX_SEND;
                end
            end
            TX_SEND: begin
                w_putOutNext     = 1'b1;
                w_payloadOutNext = pkt_byte(r_txShreg, r_txSel);
                w_txSelNext      = r_txSel + 2'd1;
                if (r_txSel == 2'(BYTES_PER_PKT - 1)) begin
                    w_txStateNext = TX_IDLE;
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_txState    <= TX_IDLE;
            r_txSel      <= '0;
            r_txShreg    <= '0;
            r_putOut     <= 1'b0;
            r_payloadOut <= 8'h00;
        end else begin
            r_txState    <= w_txStateNext;
            r_txSel      <= w_txSelNext;
            r_txShreg    <= w_txShregNext;
            r_putOut     <= w_putOutNext;
            r_payloadOut <= w_payloadOutNext;
        end
    end

endmodule

// File: tb/tb_router_port.sv
// Scoreboard bench for router_port: queues of expected packets, a negedge monitor compares
// whatever the DUT delivers on either side.
module tb_router_port;
    import router_port_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       put_inbound;
    logic [7:0] payload_inbound;
    logic       free_inbound;
    logic       free_outbound;
    logic       put_outbound;
    logic [7:0] payload_outbound;
    pkt_t       in_pkt;
    logic       in_valid;
    logic       in_ready;
    pkt_t       out_pkt;
    logic       out_valid;
    logic       out_ready;
    logic       proto_err;

    int testsRun = 0;
    int testsFailed = 0;
    logic [31:0] inQ[$];
    logic [31:0] outQ[$];
    int          txRun = 0;
    logic [31:0] txWord = '0;

    router_port #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .put_inbound      (put_inbound),
        .payload_inbound  (payload_inbound),
        .free_inbound     (free_inbound),
        .free_outbound    (free_outbound),
        .put_outbound     (put_outbound),
        .payload_outbound (payload_outbound),
        .in_pkt           (in_pkt),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_pkt          (out_pkt),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .proto_err        (proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor: pops expectations whenever a packet changes hands on either side.
    always @(negedge clk) begin
        if (rst_b) begin
            txRun  = 0;
            txWord = '0;
        end else begin
            if (in_valid && in_ready) begin
                if (inQ.size() == 0) checkOutput("in_unexpected_pkt", 1, 0);
                else checkOutput("in_pkt", in_pkt, inQ.pop_front());
            end
            if (out_valid && out_ready) outQ.push_back(out_pkt);
            if (put_outbound) begin
                txWord = {payload_outbound, txWord[31:8]};
                txRun++;
                if (txRun == 4) begin
                    if (outQ.size() == 0) checkOutput("out_unexpected_pkt", 1, 0);
                    else checkOutput("out_pkt", txWord, outQ.pop_front());
                end
            end else if (txRun != 0) begin
                checkOutput("put_run_len", txRun, 4);
                txRun = 0;
            end
        end
    end

    task automatic applyReset(input int cycles);
        @(posedge clk); #1;
        rst_b       = 1'b1;
        put_inbound = 1'b0;
        out_valid   = 1'b0;
        in_ready    = 1'b0;
        inQ.delete();
        outQ.delete();
        repeat (cycles) @(posedge clk);
        #1;
        rst_b = 1'b0;
    endtask

    // Node side: waits for free_inbound, then sends four bytes MSB first with an optional gap.
    task automatic applyStimulus(input logic [31:0] pkt, input int gap, input bit chkFree);
        int waitCycles = 0;
        while (!free_inbound && waitCycles < 300) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!free_inbound) begin
            checkOutput("free_inbound_timeout", 0, 1);
            return;
        end
        inQ.push_back(pkt);
        for (int b = 0; b < 4; b++) begin
            put_inbound     = 1'b1;
            payload_inbound = pkt[31-8*b -: 8];
            if (chkFree && b > 0) checkOutput("free_low_during_rx", free_inbound, 0);
            @(posedge clk); #1;
            if (b == 1 && gap > 0) begin
                put_inbound     = 1'b0;
                payload_inbound = 8'($urandom);
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        put_inbound = 1'b0;
    endtask

    task automatic sendPartial(input logic [31:0] pkt, input int nBytes);
        int waitCycles = 0;
        while (!free_inbound && waitCycles < 300) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!free_inbound) begin
            checkOutput("free_inbound_timeout_partial", 0, 1);
            return;
        end
        for (int b = 0; b < nBytes; b++) begin
            put_inbound     = 1'b1;
            payload_inbound = pkt[31-8*b -: 8];
            @(posedge clk); #1;
        end
        put_inbound = 1'b0;
    endtask

    task automatic offerOutbound(input logic [31:0] pkt);
        int waitCycles = 0;
        out_valid = 1'b1;
        out_pkt   = pkt;
        while (!out_ready && waitCycles < 300) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!out_ready) checkOutput("out_ready_timeout", 0, 1);
        else begin @(posedge clk); #1; end
        out_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] word;
        rst_b = 1'b1; put_inbound = 1'b0; payload_inbound = '0; free_outbound = 1'b0;
        in_ready = 1'b0; out_pkt = '0; out_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_b = 1'b0;

        checkOutput("rst_free_inbound", free_inbound, 0);
        checkOutput("rst_put_outbound", put_outbound, 0);
        checkOutput("rst_payload_outbound", payload_outbound, 0);
        checkOutput("rst_in_valid", in_valid, 0);
        checkOutput("rst_out_ready", out_ready, 1);
        checkOutput("rst_proto_err", proto_err, 0);
        @(posedge clk); #1;
        checkOutput("free_after_rst", free_inbound, 1);

        applyStimulus(32'hDEADBEEF, 0, 1);
        checkOutput("in_valid_latency", in_valid, 1);
        checkOutput("in_pkt_head", in_pkt, 32'hDEADBEEF);
        in_ready = 1'b1; @(posedge clk); #1; in_ready = 1'b0;
        checkOutput("in_valid_after_pop", in_valid, 0);

        applyStimulus(32'hAABBCCDD, 2, 1);
        in_ready = 1'b1; @(posedge clk); #1; in_ready = 1'b0;

        applyStimulus(32'h01020304, 0, 0);
        applyStimulus(32'h05060708, 0, 0);
        checkOutput("free_low_when_full", free_inbound, 0);
        put_inbound = 1'b1; payload_inbound = 8'h55;
        @(posedge clk); #1; put_inbound = 1'b0;
        checkOutput("proto_err_set", proto_err, 1);
        checkOutput("free_still_low", free_inbound, 0);
        checkOutput("in_head_unchanged", in_pkt, 32'h01020304);
        in_ready = 1'b1; repeat (3) begin @(posedge clk); #1; end in_ready = 1'b0;
        checkOutput("in_q_drained", inQ.size(), 0);

        sendPartial(32'h99887766, 2);
        applyReset(2);
        checkOutput("in_valid_after_abort", in_valid, 0);
        checkOutput("proto_err_cleared", proto_err, 0);
        @(posedge clk); #1;
        applyStimulus(32'hCAFEF00D, 0, 0);
        checkOutput("in_valid_after_rst_pkt", in_valid, 1);
        in_ready = 1'b1; @(posedge clk); #1; in_ready = 1'b0;

        word = 32'h11223344;
        free_outbound = 1'b1; out_valid = 1'b1; out_pkt = word;
        @(posedge clk); #1; out_valid = 1'b0;
        lat = 0;
        while (!put_outbound && lat < 10) begin @(posedge clk); #1; lat++; end
        checkOutput("tx_latency", lat, 2);
        for (int b = 0; b < 4; b++) begin
            checkOutput("tx_put_high", put_outbound, 1);
            checkOutput("tx_byte", payload_outbound, word[8*b +: 8]);
            if (b == 0) free_outbound = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("tx_put_low_after", put_outbound, 0);

        offerOutbound(32'hA0A1A2A3);
        offerOutbound(32'hB0B1B2B3);
        out_valid = 1'b1; out_pkt = 32'hC0C1C2C3;
        for (int k = 0; k < 3; k++) begin
            checkOutput("out_ready_full", out_ready, 0);
            checkOutput("tx_held_by_free", put_outbound, 0);
            @(posedge clk); #1;
        end
        free_outbound = 1'b1;
        offerOutbound(32'hC0C1C2C3);
        repeat (30) begin @(posedge clk); #1; end

        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    applyStimulus($urandom, int'($urandom_range(0, 2)), 0);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int p = 0; p < 25; p++) begin
                    offerOutbound($urandom);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
            end
            begin
                repeat (600) begin
                    @(posedge clk); #1;
                    in_ready      = 1'($urandom_range(0, 1));
                    free_outbound = ($urandom_range(0, 3) != 0);
                end
            end
        join

        in_ready = 1'b1; free_outbound = 1'b1;
        repeat (60) begin @(posedge clk); #1; end
        checkOutput("in_drained", inQ.size(), 0);
        checkOutput("out_drained", outQ.size(), 0);
        checkOutput("proto_err_clean", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/router_port.md
ROUTER_PORT -- requirements
Module: router_port

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per direction queue (packets).
REQ-002 SHALL have ports:
 clk  in  1  sole clock; all state updates on posedge
 rst_b  in  1  reset, synchronous, active-high
 put_inbound  in  1  node->router byte strobe
 payload_inbound  in  8  node->router byte
 free_inbound  out  1  router ready for a whole packet from node
 free_outbound  in  1  node ready for a whole packet
 put_outbound  out  1  router->node byte strobe
 payload_outbound  out  8  router->node byte
 in_pkt  out  pkt_t  head of inbound queue, to router core
 in_valid  out  1  inbound queue non-empty
 in_ready  in  1  core pops inbound head
 out_pkt  in  pkt_t  packet from router core
 out_valid  in  1  core offers out_pkt
 out_ready  out  1  outbound queue not full
 proto_err  out  1  sticky protocol-violation flag

Function
REQ-003 Link protocol: a packet is 4 bytes, one per cycle with put high; receiver samples payload on each posedge with put high; sender starts only after sampling free high.
REQ-004 Inbound byte order SHALL be MSB first: first byte -> in_pkt[31:24], fourth -> [7:0].
REQ-005 Outbound byte order SHALL be LSB first: first byte = bits[7:0], fourth = bits[31:24].
REQ-006 Inbound FSM states RX_IDLE, RX_BYTES; byte counter 2 bits.
REQ-007 RX_IDLE with free_inbound=1 and put_inbound=1: capture byte 0, count=1, go RX_BYTES.
REQ-008 RX_BYTES, put_inbound=1: capture byte at count, increment; on 4th byte push assembled packet into inbound queue on same edge, return RX_IDLE.
REQ-009 RX_BYTES, put_inbound=0: hold count and partial data (gap tolerated).
REQ-010 free_inbound SHALL be registered: next value 1 iff next state is RX_IDLE and next inbound count < DEPTH.
REQ-011 put_inbound=1 in RX_IDLE while free_inbound=0: byte dropped, no state change, proto_err set.
REQ-012 in_valid/in_pkt combinational from queue head; pop on posedge with in_valid&&in_ready; in_ready with empty queue ignored.
REQ-013 Inbound latency: in_valid high the cycle after the edge capturing byte 4 (queue previously empty).
REQ-014 Outbound queue push on posedge with out_valid&&out_ready; out_ready = (count < DEPTH), combinational.
REQ-015 Outbound FSM states TX_IDLE, TX_SEND; 2-bit select.
REQ-016 TX_IDLE, queue non-empty and free_outbound=1: pop head into shift register, go TX_SEND, select=0.
REQ-017 put_outbound SHALL be registered, high exactly 4 consecutive cycles per packet; payload_outbound = shreg byte[select], select advancing each cycle.
REQ-018 After 4th byte, return TX_IDLE; put_outbound low at least 1 cycle between packets; free_outbound sampled only in TX_IDLE.
REQ-019 Outbound latency: push at edge N into empty queue with free_outbound=1 -> pop at N+1, put_outbound high cycles N+2..N+5.
REQ-020 Both queues: simultaneous push and pop when full SHALL be permitted (count unchanged); push when full without pop ignored; pointers wrap modulo DEPTH.
REQ-021 free_outbound dropping during TX_SEND SHALL NOT abort the packet.

Reset
REQ-022 rst_b=1 at posedge: both FSMs idle, counters/pointers/queues 0, free_inbound=0 then 1 on first cycle after reset, put_outbound=0, payload_outbound=0, in_valid=0, out_ready=1, proto_err=0.
REQ-023 Reset mid-packet SHALL discard partial inbound data and abort outbound transmission (put_outbound low next cycle).

Structure
REQ-024 pkt_t (32-bit) and BYTES_PER_PKT=4 SHALL live in the shared package.
REQ-025 One sub-module pkt_fifo (parameter DEPTH, pkt_t data, combinational read, full/empty/count) SHALL be instantiated twice.

Verification
REQ-026 Node sends 0xDE,0xAD,0xBE,0xEF consecutive -> in_pkt=0xDEADBEEF, in_valid next cycle, free_inbound low during transfer.
REQ-027 Core pushes 0x11223344, free_outbound=1 -> payload_outbound 0x44,0x33,0x22,0x11 with put_outbound high 4 cycles, then low.
REQ-028 Two inbound packets, in_ready=0 -> free_inbound=0 after second; third put_inbound -> proto_err=1, queue unchanged.
REQ-029 Inbound gap: 0xAA, 0xBB, gap 2 cycles, 0xCC, 0xDD -> in_pkt=0xAABBCCDD.
REQ-030 Outbound queue full, simultaneous push/pop -> out_ready stays 0, packet order preserved; free_outbound=0 holds put_outbound low.
REQ-031 rst_b asserted after 2 inbound bytes -> no in_valid; next full packet received correctly.
